// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - fetch and data-memory handshake bundle between CPU and memory_responder
//   instruction_ready   CPU->mem  fetch request strobe
//   instruction_address CPU->mem  fetch byte address
//   instruction_wait    mem->CPU  fetch busy
//   instruction         mem->CPU  fetched word
//   memory_address      CPU->mem  data byte address
//   memory_data_store   CPU->mem  right-aligned store data
//   memory_read         CPU->mem  load request
//   memory_write        CPU->mem  store size (00 none, 01 byte, 10 half, 11 word)
//   memory_wait         mem->CPU  data port busy
//   memory_data_load    mem->CPU  aligned load word
interface memory_responder_if;
  logic        instruction_ready;
  logic [31:0] instruction_address;
  logic        instruction_wait;
  logic [31:0] instruction;
  logic [31:0] memory_address;
  logic [31:0] memory_data_store;
  logic        memory_read;
  logic [1:0]  memory_write;
  logic        memory_wait;
  logic [31:0] memory_data_load;

  modport master (
    output instruction_ready, instruction_address,
    output memory_address, memory_data_store, memory_read, memory_write,
    input  instruction_wait, instruction, memory_wait, memory_data_load
  );

  modport slave (
    input  instruction_ready, instruction_address,
    input  memory_address, memory_data_store, memory_read, memory_write,
    output instruction_wait, instruction, memory_wait, memory_data_load
  );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word RAM with independent wait-stated instruction fetch and data load/store ports
//   clk  in   clock, rising edge
//   rst  in   synchronous reset, active-low
//   bus  slave modport of memory_responder_if (fetch port + data port)
module memory_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int IWAIT      = 2,
  parameter int DWAIT      = 3
) (
  input logic               clk,
  input logic               rst,
  memory_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] I_N = IWAIT[3:0];
  localparam logic [3:0] D_N = DWAIT[3:0];

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Address bits above the array and the fetch byte offset have no effect.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.instruction_address[31:ADDR_WIDTH+2],
                              bus.instruction_address[1:0],
                              bus.memory_address[31:ADDR_WIDTH+2]};

  // ---------------- instruction fetch port ----------------
  logic [1:0]            i_state;
  logic [3:0]            i_cnt;
  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] i_rd_idx;
  logic [31:0]           i_data;

  // With zero wait states the word is read on the request edge itself,
  // before the latched index is available.
  assign i_rd_idx = (i_state == S_IDLE) ? bus.instruction_address[ADDR_WIDTH+1:2] : i_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_state <= S_IDLE;
      i_cnt   <= '0;
      i_idx   <= '0;
      i_data  <= '0;
    end else begin
      case (i_state)
        S_IDLE: if (bus.instruction_ready) begin
          i_idx <= bus.instruction_address[ADDR_WIDTH+1:2];
          if (I_N == 4'd0) begin
            i_state <= S_DONE;
            i_data  <= mem[i_rd_idx];
          end else begin
            i_state <= S_BUSY;
            i_cnt   <= I_N - 4'd1;
          end
        end
        S_BUSY: if (i_cnt == 4'd0) begin
          i_state <= S_DONE;
          i_data  <= mem[i_rd_idx];
        end else begin
          i_cnt <= i_cnt - 4'd1;
        end
        default: i_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instruction_wait = (i_state == S_BUSY);
  assign bus.instruction      = i_data;

  // ---------------- data load/store port ----------------
  logic                  d_req;
  logic [3:0]            req_be;
  logic [31:0]           req_wdata;
  logic [1:0]            d_state;
  logic [3:0]            d_cnt;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic [ADDR_WIDTH-1:0] d_rd_idx;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [31:0]           d_wdata;
  logic [31:0]           d_data;

  assign d_req    = bus.memory_read | (|bus.memory_write);
  assign d_rd_idx = (d_state == S_IDLE) ? bus.memory_address[ADDR_WIDTH+1:2] : d_idx;

  // Replicate store data into every lane so the byte enables alone pick the target lanes.
  always_comb begin
    req_be    = 4'b0000;
    req_wdata = bus.memory_data_store;
    case (bus.memory_write)
      2'b01: begin
        req_be    = 4'b0001 << bus.memory_address[1:0];
        req_wdata = {4{bus.memory_data_store[7:0]}};
      end
      2'b10: begin
        req_be    = bus.memory_address[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{bus.memory_data_store[15:0]}};
      end
      2'b11:   req_be = 4'b1111;
      default: req_be = 4'b0000;
    endcase
  end

  // Load data is captured on entry to DONE while the store only commits at the
  // end of DONE, so a combined load+store returns the pre-store word and a fetch
  // finishing alongside the store sees the old contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_state <= S_IDLE;
      d_cnt   <= '0;
      d_idx   <= '0;
      d_we    <= 1'b0;
      d_be    <= '0;
      d_wdata <= '0;
      d_data  <= '0;
    end else begin
      case (d_state)
        S_IDLE: if (d_req) begin
          d_idx   <= bus.memory_address[ADDR_WIDTH+1:2];
          d_we    <= |bus.memory_write;
          d_be    <= req_be;
          d_wdata <= req_wdata;
          if (D_N == 4'd0) begin
            d_state <= S_DONE;
            d_data  <= mem[d_rd_idx];
          end else begin
            d_state <= S_BUSY;
            d_cnt   <= D_N - 4'd1;
          end
        end
        S_BUSY: if (d_cnt == 4'd0) begin
          d_state <= S_DONE;
          d_data  <= mem[d_rd_idx];
        end else begin
          d_cnt <= d_cnt - 4'd1;
        end
        default: d_state <= S_IDLE;
      endcase
    end
  end

  // Reset on the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (rst && d_state == S_DONE && d_we) begin
      for (int i = 0; i < 4; i++) begin
        if (d_be[i]) mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

  assign bus.memory_wait      = (d_state == S_BUSY);
  assign bus.memory_data_load = d_data;

endmodule
